// File: rtl/hazard_ctrl_pkg.sv
// hazard_pkg: shared types and constants for the pipeline hazard controller.
// Holds the forwarding select encoding, controller state set and the load result-source code.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    INIT = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10,
    STEP = 2'b11
  } ctrl_state_e;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_if: pipeline <-> hazard controller signal bundle.
// The pipeline side (master) drives stage indices and requests; the controller (slave) drives stalls, flushes and forward selects.
interface hazard_if #(
  parameter int REG_ADDR_WIDTH = 5
);

  logic [REG_ADDR_WIDTH-1:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic                      regWriteE, regWriteM, regWriteW;
  logic [1:0]                resultSrcE;
  logic                      pcSrcE, memReqM, memReadyM;
  logic                      haltReq, stepReq;
  logic                      stallF, stallD, stallE, stallM;
  logic                      flushD, flushE, flushM, flushW;
  logic [1:0]                forwardAE, forwardBE;
  logic                      halted;

  modport master (
    output rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW,
    output regWriteE, regWriteM, regWriteW, resultSrcE,
    output pcSrcE, memReqM, memReadyM, haltReq, stepReq,
    input  stallF, stallD, stallE, stallM,
    input  flushD, flushE, flushM, flushW,
    input  forwardAE, forwardBE, halted
  );

  modport slave (
    input  rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW,
    input  regWriteE, regWriteM, regWriteW, resultSrcE,
    input  pcSrcE, memReqM, memReadyM, haltReq, stepReq,
    output stallF, stallD, stallE, stallM,
    output flushD, flushE, flushM, flushW,
    output forwardAE, forwardBE, halted
  );

endinterface

// File: rtl/hazard_ctrl_forward_unit.sv
// forward_unit: selects the EX operand bypass source for one source register index.
// The MEM stage result is newer than WB, so it wins when both match.
module forward_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic [REG_ADDR_WIDTH-1:0] rsE,
  input  logic [REG_ADDR_WIDTH-1:0] rdM,
  input  logic                      regWriteM,
  input  logic [REG_ADDR_WIDTH-1:0] rdW,
  input  logic                      regWriteW,
  output fwd_sel_e                  fwdSel
);

  localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO = {REG_ADDR_WIDTH{1'b0}};

  // Bypass source selection with MEM priority; x0 never forwards.
  always_comb begin
    fwdSel = FWD_NONE;
    if (regWriteM && (rdM != REG_ZERO) && (rdM == rsE)) begin
      fwdSel = FWD_MEM;
    end else if (regWriteW && (rdW != REG_ZERO) && (rdW == rsE)) begin
      fwdSel = FWD_WB;
    end else begin
      fwdSel = FWD_NONE;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forward control with a post-reset flush and halt/single-step debug FSM.
// Define HAZARD_FWD_EN for EX forwarding; without it RAW hazards interlock in decode instead.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_WIDTH    = 5,
  parameter int INIT_FLUSH_CYCLES = 2,
  parameter int DRAIN_CYCLES      = 4
) (
  input logic     clk,
  input logic     rst,
  hazard_if.slave hif
);

  localparam int INIT_W  = (INIT_FLUSH_CYCLES > 1) ? $clog2(INIT_FLUSH_CYCLES) : 1;
  localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 32'sd1);

  localparam logic [INIT_W-1:0]         INIT_ZERO  = {INIT_W{1'b0}};
  localparam logic [INIT_W-1:0]         INIT_ONE   = INIT_W'(1'b1);
  localparam logic [INIT_W-1:0]         INIT_LAST  = INIT_W'(INIT_FLUSH_CYCLES - 32'sd1);
  localparam logic [DRAIN_W-1:0]        DRAIN_ZERO = {DRAIN_W{1'b0}};
  localparam logic [DRAIN_W-1:0]        DRAIN_ONE  = DRAIN_W'(1'b1);
  localparam logic [DRAIN_W-1:0]        DRAIN_MAX  = DRAIN_W'(DRAIN_CYCLES);
  localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO   = {REG_ADDR_WIDTH{1'b0}};

  ctrl_state_e         state_r, nextState_s;
  logic [INIT_W-1:0]   initCnt_r, initCntNext_s;
  logic [DRAIN_W-1:0]  drainCnt_r, drainCntNext_s;
  logic                stepPrev_r;

  logic                memWait_s, loadUse_s, rawStall_s, stepRise_s, halted_s;
  fwd_sel_e            fwdA_s, fwdB_s;
  logic                stallF_s, stallD_s, stallE_s, stallM_s;
  logic                flushD_s, flushE_s, flushM_s, flushW_s;
  logic [1:0]          forwardAE_s, forwardBE_s;

  assign memWait_s  = hif.memReqM && !hif.memReadyM;
  assign stepRise_s = hif.stepReq && !stepPrev_r;
  assign halted_s   = (state_r == HALT) && (drainCnt_r == DRAIN_MAX);
  assign loadUse_s  = (hif.resultSrcE == RESULT_SRC_LOAD) && (hif.rdE != REG_ZERO) &&
                      ((hif.rdE == hif.rs1D) || (hif.rdE == hif.rs2D));

`ifdef HAZARD_FWD_EN
  forward_unit #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) uFwdA (
    .rsE(hif.rs1E), .rdM(hif.rdM), .regWriteM(hif.regWriteM),
    .rdW(hif.rdW), .regWriteW(hif.regWriteW), .fwdSel(fwdA_s)
  );
  forward_unit #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) uFwdB (
    .rsE(hif.rs2E), .rdM(hif.rdM), .regWriteM(hif.regWriteM),
    .rdW(hif.rdW), .regWriteW(hif.regWriteW), .fwdSel(fwdB_s)
  );
  assign rawStall_s = 1'b0;
  logic unusedRaw_s;
  assign unusedRaw_s = hif.regWriteE;
`else
  assign fwdA_s = FWD_NONE;
  assign fwdB_s = FWD_NONE;
  // WB needs no interlock: the register file writes on the falling edge.
  assign rawStall_s =
      ((hif.rs1D != REG_ZERO) && ((hif.regWriteE && (hif.rdE == hif.rs1D)) ||
                                  (hif.regWriteM && (hif.rdM == hif.rs1D)))) ||
      ((hif.rs2D != REG_ZERO) && ((hif.regWriteE && (hif.rdE == hif.rs2D)) ||
                                  (hif.regWriteM && (hif.rdM == hif.rs2D))));
  logic unusedFwd_s;
  assign unusedFwd_s = ^{hif.rs1E, hif.rs2E, hif.rdW, hif.regWriteW};
`endif

  // State, counters and step-edge history; reset abandons any halt, step or wait.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= INIT;
      initCnt_r  <= INIT_ZERO;
      drainCnt_r <= DRAIN_ZERO;
      stepPrev_r <= 1'b0;
    end else begin
      state_r    <= nextState_s;
      initCnt_r  <= initCntNext_s;
      drainCnt_r <= drainCntNext_s;
      stepPrev_r <= hif.stepReq;
    end
  end

  // Next-state and counter updates for the INIT/RUN/HALT/STEP controller.
  always_comb begin
    nextState_s    = state_r;
    initCntNext_s  = initCnt_r;
    drainCntNext_s = drainCnt_r;
    case (state_r)
      INIT: begin
        if (initCnt_r == INIT_LAST) begin
          nextState_s   = RUN;
          initCntNext_s = INIT_ZERO;
        end else begin
          initCntNext_s = initCnt_r + INIT_ONE;
        end
      end
      RUN: begin
        drainCntNext_s = DRAIN_ZERO;
        if (hif.haltReq && !memWait_s) begin
          nextState_s = HALT;
        end else begin
          nextState_s = RUN;
        end
      end
      HALT: begin
        if (!hif.haltReq) begin
          nextState_s    = RUN;
          drainCntNext_s = DRAIN_ZERO;
        end else if (stepRise_s && halted_s) begin
          nextState_s    = STEP;
          drainCntNext_s = DRAIN_ZERO;
        end else if (drainCnt_r != DRAIN_MAX) begin
          drainCntNext_s = drainCnt_r + DRAIN_ONE;
        end else begin
          drainCntNext_s = DRAIN_MAX;
        end
      end
      STEP: begin
        drainCntNext_s = DRAIN_ZERO;
        if (memWait_s) begin
          nextState_s = STEP;
        end else begin
          nextState_s = HALT;
        end
      end
      default: begin
        nextState_s    = INIT;
        initCntNext_s  = INIT_ZERO;
        drainCntNext_s = DRAIN_ZERO;
      end
    endcase
  end

  // Hazard priority is memory wait, then control flush, then data stall; state overlays follow.
  always_comb begin
    stallF_s    = 1'b0;
    stallD_s    = 1'b0;
    stallE_s    = 1'b0;
    stallM_s    = 1'b0;
    flushD_s    = 1'b0;
    flushE_s    = 1'b0;
    flushM_s    = 1'b0;
    flushW_s    = 1'b0;
    forwardAE_s = fwdA_s;
    forwardBE_s = fwdB_s;
    if (memWait_s) begin
      stallF_s = 1'b1;
      stallD_s = 1'b1;
      stallE_s = 1'b1;
      stallM_s = 1'b1;
      flushW_s = 1'b1;
    end else if (hif.pcSrcE) begin
      flushD_s = 1'b1;
      flushE_s = 1'b1;
    end else if (loadUse_s || rawStall_s) begin
      stallF_s = 1'b1;
      stallD_s = 1'b1;
      flushE_s = 1'b1;
    end else begin
      stallF_s = 1'b0;
    end
    case (state_r)
      RUN, STEP: begin
      end
      HALT: begin
        // A memory wait still holds D, so the halt bubble into D is withheld until it clears.
        stallF_s = 1'b1;
        flushD_s = !memWait_s;
      end
      default: begin
        stallF_s    = 1'b1;
        stallD_s    = 1'b0;
        stallE_s    = 1'b0;
        stallM_s    = 1'b0;
        flushD_s    = 1'b1;
        flushE_s    = 1'b1;
        flushM_s    = 1'b1;
        flushW_s    = 1'b1;
        forwardAE_s = FWD_NONE;
        forwardBE_s = FWD_NONE;
      end
    endcase
  end

  assign hif.stallF    = stallF_s;
  assign hif.stallD    = stallD_s;
  assign hif.stallE    = stallE_s;
  assign hif.stallM    = stallM_s;
  assign hif.flushD    = flushD_s;
  assign hif.flushE    = flushE_s;
  assign hif.flushM    = flushM_s;
  assign hif.flushW    = flushW_s;
  assign hif.forwardAE = forwardAE_s;
  assign hif.forwardBE = forwardBE_s;
  assign hif.halted    = halted_s;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed bench for hazard_ctrl with a per-cycle reference model and literal spot checks.
// Works with or without HAZARD_FWD_EN defined.
module tb_hazard_ctrl;

`ifdef HAZARD_FWD_EN
  localparam bit FWD_ON = 1'b1;
`else
  localparam bit FWD_ON = 1'b0;
`endif

  // Output vector: {stallF,stallD,stallE,stallM, flushD,flushE,flushM,flushW, fwdA[2], fwdB[2], halted}
  localparam logic [12:0] P_RST  = 13'b1000_1111_00_00_0;
  localparam logic [12:0] P_ZERO = 13'b0000_0000_00_00_0;
  localparam logic [12:0] P_LU   = 13'b1100_0100_00_00_0;
  localparam logic [12:0] P_CTL  = 13'b0000_1100_00_00_0;
  localparam logic [12:0] P_MW   = 13'b1111_0001_00_00_0;
  localparam logic [12:0] P_HLT  = 13'b1000_1000_00_00_0;
  localparam logic [12:0] P_HLTD = 13'b1000_1000_00_00_1;
  localparam logic [12:0] P_HWD  = 13'b1111_0001_00_00_1;
  localparam logic [12:0] P_FMEM = 13'b0000_0000_10_00_0;
  localparam logic [12:0] P_FWB  = 13'b0000_0000_01_01_0;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  hazard_if #(.REG_ADDR_WIDTH(5)) hif ();

  hazard_ctrl #(.REG_ADDR_WIDTH(5), .INIT_FLUSH_CYCLES(2), .DRAIN_CYCLES(4)) dut (
    .clk(clk),
    .rst(rst),
    .hif(hif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [12:0] got;
  assign got = {hif.stallF, hif.stallD, hif.stallE, hif.stallM,
                hif.flushD, hif.flushE, hif.flushM, hif.flushW,
                hif.forwardAE, hif.forwardBE, hif.halted};

  // Reference model: flush countdown, halt/step flags and cycles spent halted.
  int initLeft = 2;
  bit mHalt    = 1'b0;
  bit mStep    = 1'b0;
  int haltAge  = 0;
  bit prevStep = 1'b0;

  function automatic logic [1:0] fwdFor(input logic [4:0] rs);
    if (FWD_ON && hif.regWriteM && hif.rdM != 5'd0 && hif.rdM == rs) return 2'b10;
    if (FWD_ON && hif.regWriteW && hif.rdW != 5'd0 && hif.rdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit readsD(input logic [4:0] rd, input logic we);
    return we && rd != 5'd0 && (rd == hif.rs1D || rd == hif.rs2D);
  endfunction

  function automatic logic [12:0] modelOut();
    bit w, ds;
    bit sF, sD, sE, sM, fD, fE, fW;
    if (rst || initLeft > 0) return P_RST;
    w  = hif.memReqM && !hif.memReadyM;
    ds = (hif.resultSrcE == 2'b01) && readsD(hif.rdE, 1'b1);
    if (!FWD_ON) ds = ds || readsD(hif.rdE, hif.regWriteE) || readsD(hif.rdM, hif.regWriteM);
    {sF, sD, sE, sM, fD, fE, fW} = 7'b0;
    if (w) {sF, sD, sE, sM, fW} = 5'b11111;
    else if (hif.pcSrcE) {fD, fE} = 2'b11;
    else if (ds) {sF, sD, fE} = 3'b111;
    if (mHalt) begin
      sF = 1'b1;
      if (!w) fD = 1'b1;
    end
    return {sF, sD, sE, sM, fD, fE, 1'b0, fW, fwdFor(hif.rs1E), fwdFor(hif.rs2E),
            mHalt && haltAge == 4};
  endfunction

  always @(posedge clk) begin
    bit w, rise;
    if (rst) begin
      initLeft = 2; mHalt = 1'b0; mStep = 1'b0; haltAge = 0; prevStep = 1'b0;
    end else begin
      w        = hif.memReqM && !hif.memReadyM;
      rise     = hif.stepReq && !prevStep;
      prevStep = hif.stepReq;
      if (initLeft > 0) initLeft--;
      else if (mStep) begin
        if (!w) begin mStep = 1'b0; mHalt = 1'b1; haltAge = 0; end
      end else if (mHalt) begin
        if (!hif.haltReq) begin mHalt = 1'b0; haltAge = 0; end
        else if (rise && haltAge == 4) begin mHalt = 1'b0; mStep = 1'b1; haltAge = 0; end
        else if (haltAge < 4) haltAge++;
      end else if (hif.haltReq && !w) begin
        mHalt = 1'b1; haltAge = 0;
      end
    end
  end

  always @(negedge clk) begin
    logic [12:0] want;
    want = modelOut();
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL model t=%0t got=%b want=%b", $time, got, want);
    end
  end

  task automatic lit(input string name, input logic [12:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%b want=%b", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearData();
    hif.rs1D = 5'd0; hif.rs2D = 5'd0; hif.rs1E = 5'd0; hif.rs2E = 5'd0;
    hif.rdE = 5'd0; hif.rdM = 5'd0; hif.rdW = 5'd0;
    hif.regWriteE = 1'b0; hif.regWriteM = 1'b0; hif.regWriteW = 1'b0;
    hif.resultSrcE = 2'b00; hif.pcSrcE = 1'b0; hif.memReqM = 1'b0; hif.memReadyM = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clearData();
    hif.haltReq = 1'b0;
    hif.stepReq = 1'b0;
    repeat (2) tick();
    @(negedge clk); lit("reset", P_RST);
    tick(); rst = 1'b0;
    @(negedge clk); lit("init0", P_RST);
    tick(); @(negedge clk); lit("init1", P_RST);
    tick(); @(negedge clk); lit("run", P_ZERO);

    // Forwarding priority and the decode RAW interlock
    tick(); hif.rdM = 5'd5; hif.regWriteM = 1'b1; hif.rdW = 5'd5; hif.regWriteW = 1'b1; hif.rs1E = 5'd5;
    @(negedge clk); lit("fwdMem", FWD_ON ? P_FMEM : P_ZERO);
    tick(); hif.rdM = 5'd0; hif.rs2E = 5'd5;
    @(negedge clk); lit("fwdWb", FWD_ON ? P_FWB : P_ZERO);
    tick(); clearData(); hif.regWriteM = 1'b1; hif.rdM = 5'd3; hif.rs1D = 5'd3;
    @(negedge clk); lit("rawM", FWD_ON ? P_ZERO : P_LU);

    // Load-use and control flush precedence
    tick(); clearData(); hif.resultSrcE = 2'b01; hif.rdE = 5'd7; hif.rs2D = 5'd7;
    @(negedge clk); lit("loadUse", P_LU);
    tick(); hif.resultSrcE = 2'b00;
    @(negedge clk); lit("loadGone", P_ZERO);
    tick(); hif.resultSrcE = 2'b01; hif.pcSrcE = 1'b1;
    @(negedge clk); lit("loadBranch", P_CTL);

    // Memory wait suppresses the branch flush for three cycles
    tick(); clearData(); hif.memReqM = 1'b1; hif.pcSrcE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); lit("memWait", P_MW);
      tick();
    end
    hif.memReadyM = 1'b1;
    @(negedge clk); lit("memDone", P_CTL);

    // Halt, drain, single step
    tick(); clearData(); hif.haltReq = 1'b1;
    @(negedge clk); lit("haltReqRun", P_ZERO);
    for (int i = 0; i < 5; i++) begin
      tick(); @(negedge clk); lit(i == 4 ? "halted" : "draining", i == 4 ? P_HLTD : P_HLT);
    end
    tick(); hif.stepReq = 1'b1;
    @(negedge clk); lit("stepSeen", P_HLTD);
    tick(); hif.stepReq = 1'b0;
    @(negedge clk); lit("step", P_ZERO);
    for (int i = 0; i < 5; i++) begin
      tick(); @(negedge clk); lit(i == 4 ? "reHalted" : "reDrain", i == 4 ? P_HLTD : P_HLT);
    end

    // Step issued during a memory wait stays in STEP until the wait clears
    tick(); hif.stepReq = 1'b1; hif.memReqM = 1'b1;
    @(negedge clk); lit("haltWait", P_HWD);
    tick(); hif.stepReq = 1'b0;
    @(negedge clk); lit("stepWait", P_MW);
    tick(); @(negedge clk); lit("stepHeld", P_MW);
    tick(); hif.memReadyM = 1'b1;
    @(negedge clk); lit("stepFree", P_ZERO);
    tick(); clearData();
    @(negedge clk); lit("backToHalt", P_HLT);
    tick(); hif.haltReq = 1'b0;
    @(negedge clk); lit("haltDrop", P_HLT);
    tick(); @(negedge clk); lit("resume", P_ZERO);

    // Halt+step together while a memory wait blocks the halt
    tick(); hif.haltReq = 1'b1; hif.stepReq = 1'b1; hif.memReqM = 1'b1;
    @(negedge clk); lit("haltBlocked", P_MW);
    tick(); @(negedge clk); lit("haltBlocked2", P_MW);
    tick(); hif.memReadyM = 1'b1;
    @(negedge clk); lit("waitClears", P_ZERO);
    tick(); clearData();
    @(negedge clk); lit("haltAfterWait", P_HLT);
    for (int i = 0; i < 4; i++) begin
      tick(); @(negedge clk); lit(i == 3 ? "haltedSim" : "drainSim", i == 3 ? P_HLTD : P_HLT);
    end
    tick(); @(negedge clk); lit("stepLevelIgnored", P_HLTD);

    // Reset in the middle of a halt restarts the flush sequence
    tick(); rst = 1'b1;
    @(negedge clk); lit("rstMidHalt", P_RST);
    tick(); rst = 1'b0; hif.haltReq = 1'b0; hif.stepReq = 1'b0;
    @(negedge clk); lit("reinit0", P_RST);
    tick(); @(negedge clk); lit("reinit1", P_RST);
    tick(); @(negedge clk); lit("rerun", P_ZERO);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameters: REG_ADDR_WIDTH, 5, register index width; INIT_FLUSH_CYCLES, 2, post-reset flush length; DRAIN_CYCLES, 4, halt drain length.
REQ-002 SHALL have ports: clk in 1 clock; rst in 1 async active-high reset. Single clock domain.
REQ-003 SHALL have inputs: rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW (REG_ADDR_WIDTH each) for source/destination indices per stage.
REQ-004 SHALL have inputs: regWriteE, regWriteM, regWriteW (1 each) for stage write enables; resultSrcE (2) where 2'b01 marks a load in EX.
REQ-005 SHALL have inputs: pcSrcE (1) for branch taken or jump in EX; memReqM, memReadyM (1 each) for the data-memory request/ready pair.
REQ-006 SHALL have inputs: haltReq (1) as a level halt request and stepReq (1) as a single-step pulse, edge-detected internally.
REQ-007 SHALL have outputs: stallF, stallD, stallE, stallM (1 each); flushD, flushE, flushM, flushW (1 each); forwardAE, forwardBE (2 each); halted (1).

Function
REQ-008 Forwarding: forwardAE SHALL be 10 if regWriteM, rdM!=0 and rdM==rs1E; else 01 if regWriteW, rdW!=0 and rdW==rs1E; else 00. MEM SHALL take priority over WB. forwardBE SHALL use rs2E likewise.
REQ-009 Load-use: when resultSrcE==01, rdE!=0 and rdE matches rs1D or rs2D, the block SHALL assert stallF, stallD and flushE for that cycle.
REQ-010 Control hazard: pcSrcE SHALL assert flushD and flushE. If load-use is also true, flush SHALL win and stallF/stallD SHALL stay low.
REQ-011 Memory wait: memReqM && !memReadyM SHALL assert stallF/D/E/M and flushW, and SHALL suppress every other flush. The cycle after memReadyM rises SHALL proceed normally.
REQ-012 FSM states SHALL be INIT, RUN, HALT, STEP; state register and counters SHALL be sequential; all outputs SHALL be combinational from state and inputs.
REQ-013 INIT: the block SHALL assert stallF and flushD/E/M/W for exactly INIT_FLUSH_CYCLES cycles, then move to RUN.
REQ-014 RUN to HALT SHALL occur on haltReq, but not while a memory wait is active; it SHALL be taken on the first cycle the wait clears.
REQ-015 HALT: the block SHALL assert stallF and flushD every cycle. The drain counter SHALL increment and saturate at DRAIN_CYCLES. halted SHALL be 1 only when the counter==DRAIN_CYCLES.
REQ-016 HALT to RUN SHALL occur when haltReq is low, clearing the drain counter. HALT to STEP SHALL occur on a stepReq rising edge only while halted==1.
REQ-017 STEP SHALL last exactly one cycle with stallF and flushD low, releasing one instruction. It SHALL then return to HALT with the drain counter cleared.
REQ-018 Hazard rules REQ-008 to REQ-011 SHALL remain active in HALT and STEP. A memory wait in STEP SHALL hold STEP until it clears.
REQ-019 Simultaneous haltReq and stepReq in RUN SHALL enter HALT; the step SHALL be ignored.

Reset
REQ-020 On rst the FSM SHALL enter INIT, the counters SHALL clear and the step edge register SHALL clear, all asynchronously. Reset mid-halt or mid-wait SHALL abandon the operation.
REQ-021 Output values during reset SHALL be: stallF=1, flushD/E/M/W=1, stallD/E/M=0, forwardAE/BE=00, halted=0.

Configuration
REQ-022 Macro HAZARD_FWD_EN: when defined, forwarding SHALL follow REQ-008.
REQ-023 Without HAZARD_FWD_EN, forwardAE/BE SHALL be tied 00. A RAW interlock SHALL assert stallF, stallD and flushE whenever rs1D or rs2D (non-zero) matches rdE with regWriteE or rdM with regWriteM.
REQ-024 No RAW interlock SHALL be needed against WB, because the register file writes on the falling edge.

Structure
REQ-025 Package hazard_pkg SHALL hold: the fwd_sel_e enum (FWD_NONE=00, FWD_WB=01, FWD_MEM=10), the ctrl_state_e enum, and RESULT_SRC_LOAD=2'b01.
REQ-026 Sub-module forward_unit SHALL be combinational, producing one select from one source index; hazard_ctrl SHALL instantiate it twice, once for A and once for B.

Verification
REQ-027 Release rst -> flushD/E/M/W high for 2 cycles, then RUN with all stalls/flushes low.
REQ-028 rdM=5 regWriteM=1, rdW=5 regWriteW=1, rs1E=5 -> forwardAE=10; with rdM=0 instead -> forwardAE=01 (HAZARD_FWD_EN defined).
REQ-029 resultSrcE=01 rdE=7 rs2D=7 -> one cycle of stallF=stallD=flushE=1; the same with pcSrcE=1 -> flushD=flushE=1, stalls 0.
REQ-030 memReqM=1 memReadyM=0 for 3 cycles with pcSrcE=1 -> stallF/D/E/M and flushW high for 3 cycles, flushD/E low; normal flush on the 4th cycle.
REQ-031 haltReq=1 -> halted=1 after 4 cycles. stepReq pulse -> one cycle with stallF=0, then halted again 4 cycles later. haltReq=0 -> RUN.
REQ-032 Without HAZARD_FWD_EN, regWriteM=1 rdM=3 rs1D=3 -> stallF=stallD=flushE=1 and forwardAE=00.
